bconv_sequencer: RTL and testbench



---
 rtl/bconv_pkg.sv | 31 +++
 rtl/bconv_window_pe.sv | 32 +++
 rtl/bconv_sequencer.sv | 151 +++++++++++++++
 tb/tb_bconv_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bconv_pkg.sv
// Shared types and sizing helpers for the binary 3x3 convolution sequencer.
package bconv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    COMPUTE,
    WRITE,
    DONE
  } state_t;

  function automatic int out_dim(input int in_dim, input int k_dim);
    return in_dim - k_dim + 1;
  endfunction

  function automatic int pop_width(input int n_bits);
    return $clog2(n_bits + 1);
  endfunction

  // Index width that stays legal for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Kernel and window bits are packed row-major: bit i*K_W+j is (row i, col j).
  function automatic int kernel_bit(input int i, input int j, input int k_w);
    return i * k_w + j;
  endfunction

endpackage

// File: rtl/bconv_window_pe.sv
// XNOR / popcount / threshold for one K_H x K_W binary window.
module bconv_window_pe
  import bconv_pkg::*;
#(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int THRESH = (K_H * K_W + 1) / 2
) (
  input  logic [K_H*K_W-1:0] window,
  input  logic [K_H*K_W-1:0] kernel,
  output logic               out_bit
);

  localparam int NB = K_H * K_W;
  localparam int PW = pop_width(NB);

  logic [NB-1:0] match;
  logic [PW-1:0] pop;

  assign match = ~(window ^ kernel);

  // NOTE: combinational accumulation uses blocking '=' so each iteration sees the previous sum.
  always_comb begin
    pop = '0;
    for (int b = 0; b < NB; b++) begin
      pop = pop + PW'(match[b]);
    end
  end

  assign out_bit = (pop >= PW'(THRESH));

endmodule

// File: rtl/bconv_sequencer.sv
// Row-streaming controller for one binary convolution layer pass.
// Optional stall counter on perf_stall is built only when BCONV_PERF_EN is defined.
module bconv_sequencer
  import bconv_pkg::*;
#(
  parameter int INPUT_H = 28,
  parameter int INPUT_W = 28,
  parameter int K_H     = 3,
  parameter int K_W     = 3,
  parameter int THRESH  = (K_H * K_W + 1) / 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [K_H*K_W-1:0]                    kernel_i,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_req,
  output logic [idx_width(INPUT_H)-1:0]         rd_row,
  input  logic                                  rd_valid,
  input  logic [INPUT_W-1:0]                    rd_data,
  output logic                                  wr_valid,
  input  logic                                  wr_ready,
  output logic [idx_width(INPUT_H-K_H+1)-1:0]   wr_row,
  output logic [INPUT_W-K_W:0]                  wr_data,
  output logic [15:0]                           perf_stall
);

  localparam int OUTPUT_H = out_dim(INPUT_H, K_H);
  localparam int OUTPUT_W = out_dim(INPUT_W, K_W);
  localparam int NK       = K_H * K_W;
  localparam int RW       = idx_width(INPUT_H);
  localparam int OHW      = idx_width(OUTPUT_H);
  localparam int CW       = idx_width(OUTPUT_W);
  localparam int LW       = $clog2(INPUT_H + 1);

  state_t               state, state_nxt;
  logic [INPUT_W-1:0]   lb    [K_H];
  logic [INPUT_W-1:0]   lb_sh [K_H];
  logic [NK-1:0]        kernel_q;
  logic [NK-1:0]        window;
  logic [LW-1:0]        in_cnt;   // input rows fetched since start
  logic [CW-1:0]        col;
  logic                 pe_bit;

  logic start_acc, rd_take, wr_fire, fill_more, last_row, last_col;

  assign start_acc = (state == IDLE) && start;
  assign rd_take   = (state == WAIT) && rd_valid;
  assign wr_fire   = (state == WRITE) && wr_ready;
  assign fill_more = (in_cnt < LW'(K_H - 1));
  assign last_row  = (wr_row == OHW'(OUTPUT_H - 1));
  assign last_col  = (col == CW'(OUTPUT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt defaults to state first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (rd_valid) state_nxt = fill_more ? REQ : COMPUTE;
      COMPUTE: if (last_col) state_nxt = WRITE;
      WRITE:   if (wr_ready) state_nxt = last_row ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      kernel_q <= '0;
      in_cnt   <= '0;
      col      <= '0;
      wr_row   <= '0;
      wr_data  <= '0;
    end else begin
      if (start_acc) begin
        kernel_q <= kernel_i;
        in_cnt   <= '0;
        col      <= '0;
        wr_row   <= '0;
      end
      if (rd_take) begin
        in_cnt <= in_cnt + LW'(1);
        col    <= '0;
      end
      if (state == COMPUTE) begin
        wr_data[col] <= pe_bit;
        col          <= col + CW'(1);
      end
      if (wr_fire && !last_row) wr_row <= wr_row + OHW'(1);
    end
  end

  // NOTE: the line buffer is pure data storage refilled every pass, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rd_take) begin
      for (int k = 0; k < K_H - 1; k++) lb[k] <= lb[k+1];
      lb[K_H-1] <= rd_data;
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < K_H; i++) begin
      lb_sh[i] = lb[i] >> col;
      for (int j = 0; j < K_W; j++) window[kernel_bit(i, j, K_W)] = lb_sh[i][j];
    end
  end

  bconv_window_pe #(
    .K_H    (K_H),
    .K_W    (K_W),
    .THRESH (THRESH)
  ) u_pe (
    .window  (window),
    .kernel  (kernel_q),
    .out_bit (pe_bit)
  );

  assign busy     = (state == REQ) || (state == WAIT) || (state == COMPUTE) || (state == WRITE);
  assign done     = (state == DONE);
  assign rd_req   = (state == REQ);
  assign wr_valid = (state == WRITE);
  assign rd_row   = in_cnt[RW-1:0];

`ifdef BCONV_PERF_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (((state == WAIT) || ((state == WRITE) && !wr_ready)) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign perf_stall = stall_cnt;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_bconv_sequencer.sv
// Scoreboard bench: a row-level reference model fills the queue, a monitor checks each written row.
module tb_bconv_sequencer;

  localparam int IH = 28;
  localparam int IW = 28;
  localparam int KH = 3;
  localparam int KW = 3;
  localparam int OH = IH - KH + 1;
  localparam int OW = IW - KW + 1;
  localparam int TH = (KH * KW + 1) / 2;

  typedef struct {
    int            row;
    logic [OW-1:0] data;
  } exp_t;

  logic           clk, rst, start;
  logic [KH*KW-1:0] kernel_i;
  logic           busy, done, rd_req, rd_valid, wr_valid, wr_ready;
  logic [4:0]     rd_row, wr_row;
  logic [IW-1:0]  rd_data;
  logic [OW-1:0]  wr_data;
  logic [15:0]    perf_stall;

  logic [IW-1:0]  img [IH];
  exp_t           exp_q [$];
  int             rd_log [$];
  int             rd_lat = 1;
  int             stall_row = -1;
  int             stall_len = 0;
  int             stall_left = 0;
  int             errors = 0;
  int             checks = 0;
  int             cyc = 0;
  int             done_cnt = 0;

  bconv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kernel_i   (kernel_i),
    .busy       (busy),
    .done       (done),
    .rd_req     (rd_req),
    .rd_row     (rd_row),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .perf_stall (perf_stall)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Row memory: answers each request rd_lat cycles later with one rd_valid pulse.
  initial begin : responder
    int pend_cnt;
    int pend_row;
    pend_cnt = 0;
    pend_row = 0;
    rd_valid = 0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      rd_valid = 0;
      if (rst) begin
        pend_cnt = 0;
      end else begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            rd_valid = 1;
            rd_data  = img[pend_row];
          end
        end
        if (rd_req) begin
          pend_row = int'(rd_row);
          pend_cnt = rd_lat;
          rd_log.push_back(int'(rd_row));
        end
      end
    end
  end

  // Output sink and monitor: optional back-pressure on one row, then compare against the queue.
  initial begin : monitor
    exp_t          e;
    logic [OW-1:0] held;
    held     = '0;
    wr_ready = 1;
    forever begin
      @(negedge clk);
      wr_ready = 1;
      if (!rst && wr_valid) begin
        if (int'(wr_row) == stall_row && stall_left > 0) begin
          if (stall_left == stall_len) held = wr_data;
          else check("wr_data_stable", 64'(wr_data), 64'(held));
          wr_ready = 0;
          stall_left--;
        end else if (exp_q.size() == 0) begin
          check("unexpected_row", 64'(wr_row), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("wr_row_%0d", e.row), 64'(wr_row), 64'(e.row));
          check($sformatf("wr_data_%0d", e.row), 64'(wr_data), 64'(e.data));
        end
      end
    end
  end

  // Reference: each output bit counts kernel/window agreements directly from the image.
  task automatic load_expect(input logic [KH*KW-1:0] k);
    exp_t e;
    for (int r = 0; r < OH; r++) begin
      e.row  = r;
      e.data = '0;
      for (int c = 0; c < OW; c++) begin
        int agree;
        agree = 0;
        for (int i = 0; i < KH; i++)
          for (int j = 0; j < KW; j++)
            if (img[r+i][c+j] == k[i*KW+j]) agree++;
        e.data[c] = (agree >= TH);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},     64'(busy),       0);
    check({tag, "_done"},     64'(done),       0);
    check({tag, "_rd_req"},   64'(rd_req),     0);
    check({tag, "_wr_valid"}, 64'(wr_valid),   0);
    check({tag, "_rd_row"},   64'(rd_row),     0);
    check({tag, "_wr_row"},   64'(wr_row),     0);
    check({tag, "_wr_data"},  64'(wr_data),    0);
    check({tag, "_perf"},     64'(perf_stall), 0);
  endtask

  task automatic run_pass(input string tag, input logic [KH*KW-1:0] k, input int lat,
                          input int srow, input int slen, input int poke_at);
    int e0, d0, budget, exp_perf;
    rd_lat     = lat;
    stall_row  = srow;
    stall_len  = slen;
    stall_left = slen;
    exp_q.delete();
    rd_log.delete();
    load_expect(k);
    d0 = done_cnt;
    @(negedge clk);
    start    = 1;
    kernel_i = k;
    @(negedge clk);
    start    = 0;
    kernel_i = KH*KW'($urandom);
    e0       = cyc;
    check({tag, "_busy_after_start"}, 64'(busy), 1);
    budget = 0;
    while (!done && budget < 20000) begin
      @(negedge clk);
      budget++;
      if (budget == poke_at) begin
        start    = 1;
        kernel_i = ~k;
      end else begin
        start = 0;
      end
    end
    start = 0;
    check({tag, "_done_seen"}, 64'(done), 1);
    check({tag, "_latency"}, 64'(cyc - e0), 64'((1 + lat) * IH + OH * (OW + 1) + slen));
    check({tag, "_busy_at_done"}, 64'(busy), 0);
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, 64'(done_cnt - d0), 1);
    check({tag, "_rows_left"}, 64'(exp_q.size()), 0);
    check({tag, "_rd_count"}, 64'(rd_log.size()), 64'(IH));
    for (int i = 0; i < rd_log.size(); i++)
      check($sformatf("%s_rd_row_%0d", tag, i), 64'(rd_log[i]), 64'(i));
`ifdef BCONV_PERF_EN
    exp_perf = IH * lat + slen;
`else
    exp_perf = 0;
`endif
    check({tag, "_perf"}, 64'(perf_stall), 64'(exp_perf));
  endtask

  task automatic fill_random();
    for (int r = 0; r < IH; r++) img[r] = IW'($urandom);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int budget, d0;
    logic [KH*KW-1:0] k;
    rst      = 1;
    start    = 0;
    kernel_i = '0;
    for (int r = 0; r < IH; r++) img[r] = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 0;

    run_pass("zero_k000", 9'h000, 1, -1, 0, 0);
    run_pass("zero_k1ff", 9'h1FF, 1, -1, 0, 0);

    img[5][7] = 1'b1;
    run_pass("single", 9'h010, 1, -1, 0, 0);

    fill_random();
    run_pass("stall", KH*KW'($urandom), 4, 10, 3, 0);

    for (int p = 0; p < 3; p++) begin
      fill_random();
      run_pass($sformatf("rand%0d", p), KH*KW'($urandom), int'($urandom_range(1, 3)), -1, 0,
               (p == 1) ? 300 : 0);
    end

    // Abort a pass in the middle of computing output row 12.
    fill_random();
    k = KH*KW'($urandom);
    rd_lat = 1;
    stall_row = -1;
    stall_len = 0;
    exp_q.delete();
    load_expect(k);
    d0 = done_cnt;
    @(negedge clk);
    start    = 1;
    kernel_i = k;
    @(negedge clk);
    start  = 0;
    budget = 0;
    while (!(rd_req && rd_row == 5'd14) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check("abort_reached_row14", 64'(rd_row), 14);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_idle("abort");
    exp_q.delete();
    rd_log.delete();
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 0);
    check("abort_no_reads", 64'(rd_log.size()), 0);

    run_pass("after_abort", KH*KW'($urandom), 1, -1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
